// File: rtl/vga_varredura_if.sv
// vga_varredura_if: frame-buffer read port and VGA pin bundle of the raster scanner
interface vga_varredura_if;
  logic [8:0]  pixel_in;
  logic [18:0] endereco;
  logic        hsync;
  logic        vsync;
  logic [2:0]  vga_r;
  logic [2:0]  vga_g;
  logic [2:0]  vga_b;
  logic        ativo;
  logic        vblank;
  logic        inicio_quadro;
  modport master (
    input  pixel_in,
    output endereco, hsync, vsync, vga_r, vga_g, vga_b, ativo, vblank, inicio_quadro
  );
  modport slave (
    output pixel_in,
    input  endereco, hsync, vsync, vga_r, vga_g, vga_b, ativo, vblank, inicio_quadro
  );
endinterface

// File: rtl/vga_varredura.sv
// vga_varredura: 640x480@60 VGA raster scanner reading a 9-bit frame buffer; VGA_PADRAO_TESTE_EN swaps pixel_in for colour bars
module vga_varredura #(
  parameter int H_ATIVO = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_ATIVO = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int DIV     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_varredura_if.master  bus
);
  localparam int H_TOT = H_ATIVO + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ATIVO + V_FP + V_SYNC + V_BP;
  localparam int HS_INI = H_ATIVO + H_FP;
  localparam int HS_FIM = HS_INI + H_SYNC;
  localparam int VS_INI = V_ATIVO + V_FP;
  localparam int VS_FIM = VS_INI + V_SYNC;
  localparam logic [18:0] END_MAX = 19'(H_ATIVO * V_ATIVO - 1);
  logic [3:0]  r_div;
  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic [18:0] r_end;
  logic        r_inicio;
  logic        r_hs1, r_vs1, r_at1;
  logic [8:0]  r_pix1;
  logic        r_hs2, r_vs2, r_at2;
  logic [8:0]  r_rgb2;
  logic        w_tick;
  logic        w_h_fim;
  logic        w_v_fim;
  logic        w_at0;
  logic        w_hs0;
  logic        w_vs0;
  logic [8:0]  w_pix0;
  assign w_tick  = r_div == 4'(DIV - 1);
  assign w_h_fim = r_h == 10'(H_TOT - 1);
  assign w_v_fim = r_v == 10'(V_TOT - 1);
  assign w_at0   = r_h < 10'(H_ATIVO) && r_v < 10'(V_ATIVO);
  assign w_hs0   = !(r_h >= 10'(HS_INI) && r_h < 10'(HS_FIM));
  assign w_vs0   = !(r_v >= 10'(VS_INI) && r_v < 10'(VS_FIM));
`ifdef VGA_PADRAO_TESTE_EN
  logic [2:0] w_barra;
  assign w_barra = 3'(r_h / 10'd80);
  assign w_pix0  = {{3{w_barra[2]}}, {3{w_barra[1]}}, {3{w_barra[0]}}};
`else
  assign w_pix0  = bus.pixel_in;
`endif
  // Pixel-tick divider, raster counters and the read address that tracks them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_h      <= '0;
      r_v      <= '0;
      r_end    <= '0;
      r_inicio <= 1'b0;
    end else begin
      r_div    <= w_tick ? '0 : r_div + 4'd1;
      r_inicio <= w_tick && w_h_fim && w_v_fim;
      if (w_tick) begin
        r_h <= w_h_fim ? '0 : r_h + 10'd1;
        if (w_h_fim) r_v <= w_v_fim ? '0 : r_v + 10'd1;
        if ((w_h_fim && w_v_fim) || (w_at0 && r_end == END_MAX)) r_end <= '0;
        else if (w_at0) r_end <= r_end + 19'd1;
      end
    end
  end
  // Two-tick output pipeline: stage 1 captures the fetched pixel, stage 2 drives the pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_at1  <= 1'b0;
      r_pix1 <= '0;
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
      r_at2  <= 1'b0;
      r_rgb2 <= '0;
    end else if (w_tick) begin
      r_hs1  <= w_hs0;
      r_vs1  <= w_vs0;
      r_at1  <= w_at0;
      r_pix1 <= w_pix0;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_at2  <= r_at1;
      r_rgb2 <= r_at1 ? r_pix1 : 9'd0;
    end
  end
  assign bus.endereco      = r_end;
  assign bus.hsync         = r_hs2;
  assign bus.vsync         = r_vs2;
  assign bus.ativo         = r_at2;
  assign {bus.vga_r, bus.vga_g, bus.vga_b} = r_rgb2;
  assign bus.vblank        = r_v >= 10'(V_ATIVO);
  assign bus.inicio_quadro = r_inicio;
endmodule

// File: tb/tb_vga_varredura.sv
// tb_vga_varredura: randomized self-checking bench comparing vga_varredura against a raster-position model
module tb_vga_varredura;
  typedef struct packed {
    logic [18:0] ender;
    logic        hs;
    logic        vs;
    logic        at;
    logic        vb;
    logic [8:0]  rgb;
  } saida_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] salt;
  int         c;
  int         n_ok;
  int         n_tot;
  always #5 clk = ~clk;
  vga_varredura_if ifa ();
  vga_varredura_if ifb ();
  vga_varredura dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  vga_varredura #(
    .H_ATIVO(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ATIVO(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .DIV(2)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs === exp) n_ok++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask
  // Expected pins after m pixel ticks since reset: counters sit at tick m, the pins show tick m-2
  function automatic saida_t modelo(input int ha, hf, hsw, hb, va, vf, vsw, vbp, m);
    int ht, f, pos, h, v, a;
    saida_t s;
    ht = ha + hf + hsw + hb;
    f = ht * (va + vf + vsw + vbp);
    pos = m % f;
    h = pos % ht;
    v = pos / ht;
    s.vb = v >= va;
    s.ender = 19'((v >= va || (h >= ha && v == va - 1)) ? 0 : (h < ha) ? v * ha + h : (v + 1) * ha);
    s.hs = 1'b1;
    s.vs = 1'b1;
    s.at = 1'b0;
    s.rgb = '0;
    if (m >= 2) begin
      pos = (m - 2) % f;
      h = pos % ht;
      v = pos / ht;
      s.hs = !(h >= ha + hf && h < ha + hf + hsw);
      s.vs = !(v >= va + vf && v < va + vf + vsw);
      s.at = h < ha && v < va;
      a = v * ha + h;
`ifdef VGA_PADRAO_TESTE_EN
      begin
        logic [2:0] bar;
        bar = 3'(h / 80);
        if (s.at) s.rgb = {{3{bar[2]}}, {3{bar[1]}}, {3{bar[0]}}};
      end
`else
      if (s.at) s.rgb = 9'(a) ^ salt;
`endif
    end
    return s;
  endfunction
  function automatic saida_t junta(input logic [18:0] e, input logic hs, vs, at, vb, input logic [2:0] r, g, b);
    return {e, hs, vs, at, vb, r, g, b};
  endfunction
  task automatic compara(input string p, input saida_t o, input saida_t e, input logic ini, input logic ini_e);
    verifica({p, ".endereco"}, 32'(o.ender), 32'(e.ender));
    verifica({p, ".hsync"}, 32'(o.hs), 32'(e.hs));
    verifica({p, ".vsync"}, 32'(o.vs), 32'(e.vs));
    verifica({p, ".ativo"}, 32'(o.at), 32'(e.at));
    verifica({p, ".vblank"}, 32'(o.vb), 32'(e.vb));
    verifica({p, ".rgb"}, 32'(o.rgb), 32'(e.rgb));
    verifica({p, ".inicio_quadro"}, 32'(ini), 32'(ini_e));
  endtask
  task automatic confere(input string p, input saida_t o, input logic ini,
                         input int ha, hf, hsw, hb, va, vf, vsw, vbp, div);
    int m, f;
    m = c / div;
    f = (ha + hf + hsw + hb) * (va + vf + vsw + vbp);
    compara(p, o, modelo(ha, hf, hsw, hb, va, vf, vsw, vbp, m), ini, c % div == 0 && m > 0 && m % f == 0);
  endtask
  task automatic amostra(input logic em_reset);
    saida_t oa, ob, rst_e;
    oa = junta(ifa.endereco, ifa.hsync, ifa.vsync, ifa.ativo, ifa.vblank, ifa.vga_r, ifa.vga_g, ifa.vga_b);
    ob = junta(ifb.endereco, ifb.hsync, ifb.vsync, ifb.ativo, ifb.vblank, ifb.vga_r, ifb.vga_g, ifb.vga_b);
    rst_e = {19'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0};
    if (em_reset) begin
      compara("rst_a", oa, rst_e, ifa.inicio_quadro, 1'b0);
      compara("rst_b", ob, rst_e, ifb.inicio_quadro, 1'b0);
    end else begin
      confere("a", oa, ifa.inicio_quadro, 640, 16, 96, 48, 480, 10, 2, 33, 1);
      confere("b", ob, ifb.inicio_quadro, 16, 2, 4, 3, 6, 1, 2, 2, 2);
    end
  endtask
  // Frame-buffer stand-in: data for the current address settles within the clk after it changes
  task automatic ciclo(input logic em_reset);
    @(negedge clk);
    if (!em_reset) c++;
    amostra(em_reset);
    ifa.pixel_in = ifa.endereco[8:0] ^ salt;
    ifb.pixel_in = ifb.endereco[8:0] ^ salt;
  endtask
  initial begin
    n_ok = 0;
    n_tot = 0;
    c = 0;
    salt = 9'($urandom);
    ifa.pixel_in = salt;
    ifb.pixel_in = salt;
    repeat (5) ciclo(1'b1);
    rst_n = 1'b1;
    repeat (4000 + $urandom_range(0, 1000)) ciclo(1'b0);
    #2 rst_n = 1'b0;
    #1 amostra(1'b1);
    c = 0;
    repeat ($urandom_range(2, 6)) ciclo(1'b1);
    rst_n = 1'b1;
    repeat (3000) ciclo(1'b0);
    $display("%0d/%0d checks passed", n_ok, n_tot);
    $finish;
  end
endmodule
